// File: rtl/fifo_burst_ctrl.sv
// fifo_burst_ctrl: fills the ADC sample FIFO with one burst, then drains it into
// the FIR under a ready/valid handshake and pulses done when the last word is out.
module fifo_burst_ctrl #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             adc_valid_i,
  input  logic             full_i,
  input  logic             empty_i,
  input  logic             fir_ready_i,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic             fir_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic [2:0] {StIdle, StFill, StDrain, StFlush, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BURST_LEN - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  // One bit per read in flight; the top bit is the word at the FIFO output now.
  logic [RD_LAT-1:0] r_vld;

  logic w_wr;
  logic w_rd;

  // FIFO strobes: decoded from the registered state, killed in abort/reset cycles.
  always_comb begin
    w_wr = (r_state == StFill) & adc_valid_i & ~full_i & ~abort_i & ~rst_i;
    w_rd = (r_state == StDrain) & fir_ready_i & ~empty_i & ~abort_i & ~rst_i;
  end

  // Burst sequencer, sample counter, sticky overflow and read-valid pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_vld   <= '0;
    end else if (abort_i) begin
      // Counter and overflow are left as-is so the control block can inspect them.
      r_state <= StIdle;
      r_vld   <= '0;
    end else begin
      r_vld <= (r_vld << 1) | RD_LAT'(w_rd);
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_state <= StFill;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        StFill: begin
          if (adc_valid_i && full_i) r_ovf <= 1'b1;
          if (w_wr) begin
            if (r_cnt == LastCnt) begin
              r_state <= StDrain;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StDrain: begin
          if (w_rd) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LastCnt) r_state <= StFlush;
          end
        end
        StFlush: begin
          // Leave only once every word already read has been presented to the FIR.
          if (r_vld == '0) r_state <= StDone;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign wr_en_o     = w_wr;
  assign rd_en_o     = w_rd;
  assign fir_valid_o = r_vld[RD_LAT-1];
  assign busy_o      = (r_state != StIdle);
  assign done_o      = (r_state == StDone);
  assign overflow_o  = r_ovf;
  assign cnt_o       = r_cnt;

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Bench for fifo_burst_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a phase/queue level reference model.
module tb_fifo_burst_ctrl;
  localparam int B = 16;
  localparam int L = 2;
  localparam int W = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, start_i, abort_i, adc_valid_i, full_i, empty_i, fir_ready_i;
  logic wr_en_o, rd_en_o, fir_valid_o, busy_o, done_o, overflow_o;
  logic [W-1:0] cnt_o;

  fifo_burst_ctrl #(.BURST_LEN(B), .CNT_W(W), .RD_LAT(L)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .adc_valid_i(adc_valid_i), .full_i(full_i), .empty_i(empty_i),
    .fir_ready_i(fir_ready_i), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .fir_valid_o(fir_valid_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o), .cnt_o(cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 fill, 2 drain, 3 flush, 4 done.
  int m_phase = 0;
  int m_cnt   = 0;
  bit m_ovf   = 1'b0;
  int due[$];          // cycles at which a read word is presented to the FIR
  int cyc     = 0;

  int n_wr, n_rd, n_vld, n_done, done_cyc, start_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_tally();
    n_wr = 0; n_rd = 0; n_vld = 0; n_done = 0; done_cyc = -1;
  endtask

  // One clock: drive inputs, compare all outputs with the model, advance the model.
  task automatic step(input bit rs, input bit st, input bit ab, input bit av,
                      input bit fu, input bit em, input bit rdy);
    bit e_wr, e_rd, e_vld;
    @(negedge clk);
    rst_i = rs; start_i = st; abort_i = ab; adc_valid_i = av;
    full_i = fu; empty_i = em; fir_ready_i = rdy;
    #1;
    e_wr  = (m_phase == 1) && av && !fu && !ab && !rs;
    e_rd  = (m_phase == 2) && rdy && !em && !ab && !rs;
    e_vld = (due.size() > 0) && (due[0] == cyc);
    chk("wr_en", 32'(wr_en_o), 32'(e_wr));
    chk("rd_en", 32'(rd_en_o), 32'(e_rd));
    chk("fir_valid", 32'(fir_valid_o), 32'(e_vld));
    chk("busy", 32'(busy_o), 32'(m_phase != 0));
    chk("done", 32'(done_o), 32'(m_phase == 4));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("cnt", 32'(cnt_o), 32'(m_cnt));
    if (wr_en_o === 1'b1) n_wr++;
    if (rd_en_o === 1'b1) n_rd++;
    if (fir_valid_o === 1'b1) n_vld++;
    if (done_o === 1'b1) begin n_done++; done_cyc = cyc; end

    if (rs) begin
      m_phase = 0; m_cnt = 0; m_ovf = 1'b0; due.delete();
    end else if (ab) begin
      m_phase = 0; due.delete();
    end else begin
      case (m_phase)
        0: if (st) begin m_phase = 1; m_cnt = 0; m_ovf = 1'b0; end
        1: begin
          if (av && fu) m_ovf = 1'b1;
          if (e_wr) begin
            m_cnt++;
            if (m_cnt == B) begin m_phase = 2; m_cnt = 0; end
          end
        end
        2: if (e_rd) begin
          m_cnt++;
          due.push_back(cyc + L);
          if (m_cnt == B) m_phase = 3;
        end
        3: if (due.size() == 0) m_phase = 4;
        default: m_phase = 0;
      endcase
      if (due.size() > 0 && due[0] == cyc) void'(due.pop_front());
    end
    cyc++;
  endtask

  initial begin
    int k;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; adc_valid_i = 1'b0;
    full_i = 1'b0; empty_i = 1'b0; fir_ready_i = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);   // reset state checked by the model

    // Nominal burst, continuous valid/ready.
    clear_tally();
    start_cyc = cyc;
    step(0, 1, 0, 1, 0, 0, 1);
    repeat (40) step(0, 0, 0, 1, 0, 0, 1);
    chk("nom_wr_count", 32'(n_wr), 32'(B));
    chk("nom_rd_count", 32'(n_rd), 32'(B));
    chk("nom_vld_count", 32'(n_vld), 32'(B));
    chk("nom_done_count", 32'(n_done), 32'd1);
    chk("nom_done_latency", 32'(done_cyc - start_cyc), 32'(2 * B + L + 2));
    chk("nom_overflow", 32'(overflow_o), 32'd0);

    // Sparse ADC strobes.
    clear_tally();
    step(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 120; i++) step(0, 0, 0, (i % 4) == 3, 0, 0, 1);
    chk("sparse_wr_count", 32'(n_wr), 32'(B));
    chk("sparse_done_count", 32'(n_done), 32'd1);

    // Overflow: three strobes land while full.
    clear_tally();
    step(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 120; i++)
      step(0, 0, 0, (i % 4) == 0, (i == 4) || (i == 8) || (i == 12), 0, 1);
    chk("ovf_wr_count", 32'(n_wr), 32'(B));
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    chk("ovf_done_count", 32'(n_done), 32'd1);

    // Backpressure plus empty stall in DRAIN.
    clear_tally();
    step(0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 120; i++) step(0, 0, 0, 1, 0, (i >= 20) && (i < 25), (i % 2) == 0);
    chk("bp_rd_count", 32'(n_rd), 32'(B));
    chk("bp_vld_count", 32'(n_vld), 32'(B));

    // Abort after 7 reads.
    step(0, 1, 0, 1, 0, 0, 0);
    clear_tally();
    k = 0;
    while (n_rd < 7 && k < 100) begin step(0, 0, 0, 1, 0, 0, 1); k++; end
    chk("abort_reads_reached", 32'(n_rd), 32'd7);
    step(0, 0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("abort_cnt_held", 32'(cnt_o), 32'd7);
    chk("abort_idle", 32'(busy_o), 32'd0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 1);
    chk("abort_no_done", 32'(n_done), 32'd0);

    // Start and abort together in IDLE.
    step(0, 1, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("start_abort_idle", 32'(busy_o), 32'd0);

    // Reset during FILL, with an overflow recorded first.
    step(0, 1, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 0, 1);
    repeat (4) step(0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_fill_cnt", 32'(cnt_o), 32'd0);
    chk("rst_fill_ovf", 32'(overflow_o), 32'd0);
    chk("rst_fill_busy", 32'(busy_o), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(499) == 0, $urandom_range(19) == 0, $urandom_range(199) == 0,
           $urandom_range(1) == 1, $urandom_range(7) == 0, $urandom_range(7) == 0,
           $urandom_range(9) < 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
